uart_tx_core: RTL and testbench

UART transmitter, the transmit-side counterpart of the RX start-check, sampling and deserializer chain in the processing system. It accepts a parallel word with a one-cycle valid strobe and serializes it on a single line as a start bit, data bits LSB first, an optional parity bit and a stop bit. Each bit is held for `prescale` clock cycles, so one system clock drives the block and it matches the RX oversampling ratio. `Busy` tells the upstream FIFO or controller when a new word can be issued.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_core_if.sv | 23 ++
 rtl/uart_tx_serializer.sv | 39 +++
 rtl/uart_tx_core.sv | 101 ++++++++++
 tb/tb_uart_tx_core.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and parity polarity, common to TX and RX.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// Upstream-facing request/line bundle of the UART transmitter.
interface uart_tx_core_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned prescale_width = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [prescale_width-1:0] prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Load/shift register with bit index; bit_c looks ahead to the bit visible after this edge.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift_en,
    output logic                  bit_c,
    output logic                  last_bit
);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_inc;
    logic [DATA_WIDTH:0]   shreg_ext;

    assign idx_inc   = idx + IDX_W'(1);
    assign shreg_ext = {1'b0, shreg};
    assign bit_c     = shift_en ? shreg_ext[1] : shreg_ext[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            idx      <= '0;
            last_bit <= 1'b0;
        end else if (load) begin
            shreg    <= data;
            idx      <= '0;
            last_bit <= (DATA_WIDTH == 1);
        end else if (shift_en) begin
            shreg    <= {1'b0, shreg[DATA_WIDTH-1:1]};
            idx      <= idx_inc;
            last_bit <= (idx_inc == IDX_W'(DATA_WIDTH - 1));
        end
    end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, LSB-first data, optional parity, stop; each bit held prescale cycles.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned prescale_width = 6
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_core_if.slave bus
);
    logic [2:0]                state_q, state_n;
    logic [prescale_width-1:0] cnt_q, cnt_n;
    logic [prescale_width-1:0] prescale_q;
    logic [prescale_width-1:0] last_cnt_c;
    logic                      par_en_q, par_bit_q;
    logic                      tx_q, tx_n, busy_q, busy_n;
    logic                      period_end_c, load_c, shift_c;
    logic                      ser_bit_c, last_bit;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (load_c),
        .data     (bus.P_DATA),
        .shift_en (shift_c),
        .bit_c    (ser_bit_c),
        .last_bit (last_bit)
    );

    // A prescale of 0 behaves as 1 cycle per bit
    assign last_cnt_c   = (prescale_q == '0) ? '0 : prescale_q - prescale_width'(1);
    assign period_end_c = (cnt_q == last_cnt_c);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        cnt_n   = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Data_Valid) begin
                    state_n = ST_START;
                    load_c  = 1'b1;
                end
            end
            ST_START:  if (period_end_c) state_n = ST_DATA;
            ST_DATA: begin
                if (period_end_c) begin
                    if (last_bit) state_n = par_en_q ? ST_PARITY : ST_STOP;
                    else          shift_c = 1'b1;
                end
            end
            ST_PARITY: if (period_end_c) state_n = ST_STOP;
            ST_STOP:   if (period_end_c) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        // Counter restarts on every state entry and at each bit boundary
        if (state_n != ST_IDLE && state_n == state_q && !period_end_c)
            cnt_n = cnt_q + prescale_width'(1);

        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = ser_bit_c;
            ST_PARITY: tx_n = par_bit_q;
            default:   tx_n = 1'b1;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q      <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            tx_q   <= tx_n;
            busy_q <= busy_n;
            if (load_c) begin
                prescale_q <= bus.prescale;
                par_en_q   <= bus.PAR_EN;
                par_bit_q  <= (^bus.P_DATA) ^ (bus.PAR_TYP == PAR_ODD);
            end
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized self-checking bench for uart_tx_core against a frame-level bit-list model.
module tb_uart_tx_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_core_if #(.DATA_WIDTH(8), .prescale_width(6)) bus ();

    uart_tx_core #(.DATA_WIDTH(8), .prescale_width(6)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    // Expected line levels for one frame, one entry per bit period
    function automatic int frame_bits(input logic [7:0] d, input logic pen, input logic ptyp,
                                      output logic bits [12]);
        int len = 0;
        int ones;
        for (int i = 0; i < 12; i++) bits[i] = 1'b1;
        bits[len] = 1'b0; len++;
        for (int i = 0; i < 8; i++) begin bits[len] = d[i]; len++; end
        if (pen) begin
            ones = $countones(d);
            // even: total ones incl. parity even; odd: total ones odd
            bits[len] = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
            len++;
        end
        bits[len] = 1'b1; len++;
        return len;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic [5:0] psc, input int inj, input string name,
                              output int busy_cnt);
        logic bits [12];
        int len, p, cyc;
        logic slot_bad, got_tx, got_busy;
        len = frame_bits(d, pen, ptyp, bits);
        p   = (psc == 0) ? 1 : int'(psc);
        bus.P_DATA = d; bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.prescale = psc;
        bus.Data_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Data_Valid = 1'b0;
        bus.P_DATA   = 8'($urandom);
        bus.PAR_EN   = 1'($urandom);
        bus.PAR_TYP  = 1'($urandom);
        bus.prescale = 6'($urandom);
        busy_cnt = 0;
        for (int s = 0; s < len; s++) begin
            slot_bad = 1'b0; got_tx = 1'b1; got_busy = 1'b1;
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                cyc = s * p + c;
                if (cyc == inj) begin bus.Data_Valid = 1'b1; bus.P_DATA = 8'h00; end
                else if (cyc == inj + 1) bus.Data_Valid = 1'b0;
                if (bus.Busy === 1'b1) busy_cnt++;
                if (!slot_bad && (bus.TX_OUT !== bits[s] || bus.Busy !== 1'b1)) begin
                    slot_bad = 1'b1; got_tx = bus.TX_OUT; got_busy = bus.Busy;
                end
            end
            n_tests++;
            if (slot_bad) begin
                n_fail++;
                $display("FAIL %s bit%0d: tx=%b busy=%b, required tx=%b busy=1",
                         name, s, got_tx, got_busy, bits[s]);
            end
        end
        bus.Data_Valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: tx=%b busy=%b, required tx=1 busy=0",
                     name, bus.TX_OUT, bus.Busy);
        end
        n_tests++;
        if (busy_cnt != len * p) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d, required %0d", name, busy_cnt, len * p);
        end
    endtask

    task automatic test_reset();
        bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.prescale = 6'd1;
        bus.Data_Valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: tx=%b busy=%b, required tx=1 busy=0", bus.TX_OUT, bus.Busy);
        end
        bus.Data_Valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_even_parity();
        int bc;
        send_frame(8'hA5, 1'b1, 1'b0, 6'd8, -10, "even_a5", bc);
        n_tests++;
        if (bc != 88) begin
            n_fail++;
            $display("FAIL even_a5 busy88: got %0d, required 88", bc);
        end
    endtask

    task automatic test_odd_parity();
        int bc;
        send_frame(8'h01, 1'b1, 1'b1, 6'd3, -10, "odd_01", bc);
        send_frame(8'h01, 1'b1, 1'b0, 6'd3, -10, "even_01", bc);
    endtask

    task automatic test_no_parity();
        int bc;
        send_frame(8'hFF, 1'b0, 1'b0, 6'd4, -10, "nopar_ff", bc);
        n_tests++;
        if (bc != 40) begin
            n_fail++;
            $display("FAIL nopar_ff busy40: got %0d, required 40", bc);
        end
    endtask

    task automatic test_random();
        int bc;
        for (int i = 0; i < 20; i++)
            send_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       6'($urandom_range(0, 7)), -10, "random", bc);
    endtask

    task automatic test_ignore_busy();
        int bc, bad;
        // pulse lands in data bit 2 with prescale 4
        send_frame(8'h5A, 1'($urandom), 1'($urandom), 6'd4, 13, "ignore_5a", bc);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL ignore_no_second: %0d non-idle cycles, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int bc, bad;
        d = 8'($urandom);
        bus.P_DATA = d; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.prescale = 6'd4;
        bus.Data_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Data_Valid = 1'b0;
        repeat (4 * 4 + 2) @(negedge clk);
        n_tests++;
        if (bus.TX_OUT !== d[3] || bus.Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_bit3: tx=%b busy=%b, required tx=%b busy=1",
                     bus.TX_OUT, bus.Busy, d[3]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: tx=%b busy=%b, required tx=1 busy=0",
                     bus.TX_OUT, bus.Busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: %0d non-idle cycles, required 0", bad);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 6'd4, -10, "after_rst_3c", bc);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [5];
        logic bits [12];
        int len, bad;
        for (int f = 0; f < 5; f++) d[f] = 8'($urandom);
        bus.P_DATA = d[0]; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.prescale = 6'd0;
        bus.Data_Valid = 1'b1;
        @(posedge clk);
        for (int f = 0; f < 4; f++) begin
            #1;
            bus.P_DATA = d[f+1];
            len = frame_bits(d[f], 1'b0, 1'b0, bits);
            bad = 0;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (bus.TX_OUT !== bits[c] || bus.Busy !== 1'b1) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL b2b frame%0d: %0d wrong cycles, required 0", f, bad);
            end
            @(negedge clk);
            n_tests++;
            if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b gap%0d: tx=%b busy=%b, required tx=1 busy=0",
                         f, bus.TX_OUT, bus.Busy);
            end
            if (f == 3) bus.Data_Valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_random();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
